// File: rtl/fifo_wr.sv
// Burst writer: waits for the FIFO to drain, settles WAIT_CYC cycles, then streams an incrementing count until full.
// Optional build macro FIFO_WR_BURST_LIMIT_EN additionally caps each burst at DEPTH words.
module fifo_wr #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrempty,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [DATA_W-1:0] wrdata,
  output logic              burst_done,
  output logic [15:0]       burst_cnt
);

  // state | meaning
  // IDLE  | no request; waiting for wrempty
  // WAIT  | settle counter running; wrempty/wrfull ignored
  // WRITE | wrreq high, data incrementing; ends on wrfull (or burst limit)
  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  // WAIT_CYC=0 is treated as a single settle cycle
  localparam int WAIT_EFF = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_EFF - 1);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             at_limit;
  logic             stop;

`ifdef FIFO_WR_BURST_LIMIT_EN
  localparam int DEPTH_EFF = (DEPTH < 1) ? 1 : DEPTH;
  localparam int WC_W      = (DEPTH_EFF > 1) ? $clog2(DEPTH_EFF) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(DEPTH_EFF - 1);

  logic [WC_W-1:0] word_cnt;

  // word_cnt holds words already accepted; the one on the bus now is the DEPTH-th
  assign at_limit = (word_cnt == WC_LAST);
`else
  assign at_limit = 1'b0;
`endif

  assign stop = wrfull || at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      wrreq      <= 1'b0;
      wrdata     <= '0;
      burst_done <= 1'b0;
      burst_cnt  <= '0;
`ifdef FIFO_WR_BURST_LIMIT_EN
      word_cnt   <= '0;
`endif
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          wrreq      <= 1'b0;
          settle_cnt <= '0;
          if (wrempty) state <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == WAIT_LAST) begin
            state  <= WRITE;
            wrreq  <= 1'b1;
            wrdata <= '0;
`ifdef FIFO_WR_BURST_LIMIT_EN
            word_cnt <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        WRITE: begin
          // the word on the bus when wrfull rises is dropped by the FIFO; no resend
          if (stop) begin
            state      <= IDLE;
            wrreq      <= 1'b0;
            burst_done <= 1'b1;
            burst_cnt  <= burst_cnt + 16'd1;
          end else begin
            wrdata <= wrdata + 1'b1;
`ifdef FIFO_WR_BURST_LIMIT_EN
            word_cnt <= word_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          wrreq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr.sv
// Scoreboard bench for fifo_wr: expected burst words are queued at burst start and popped per wrreq cycle.
module tb_fifo_wr;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 64;
  localparam int WAIT_CYC = 3;
`ifdef FIFO_WR_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wrempty = 1'b0;
  logic              wrfull = 1'b0;
  logic              wrreq;
  logic [DATA_W-1:0] wrdata;
  logic              burst_done;
  logic [15:0]       burst_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  int sb_q[$];

  fifo_wr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wrempty    (wrempty),
    .wrfull     (wrfull),
    .wrreq      (wrreq),
    .wrdata     (wrdata),
    .burst_done (burst_done),
    .burst_cnt  (burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // From IDLE: sample wrempty, run through WAIT, return #1 after wrreq rises.
  task automatic start_burst(input bit ign);
    int edges;
    wrempty = 1'b1;
    tick();
    edges = 1;
    chk("wait_no_req", int'(wrreq), 0);
    wrempty = ign;
    wrfull  = ign;
    while (!wrreq && edges < 20) begin
      tick();
      edges++;
    end
    wrfull = 1'b0;
    chk("start_latency", edges, WAIT_CYC + 1);
    chk("start_data", int'(wrdata), 0);
  endtask

  // Burst already started; wrfull is raised during the n-th presented word.
  task automatic finish_burst(input int n);
    int eff;
    int got;
    int exp_w;
    eff = (LIMIT_EN && n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < eff; k++) sb_q.push_back(k % (1 << DATA_W));
    got = 0;
    while (wrreq && got < 2000) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_word", got, eff);
      end else begin
        exp_w = sb_q.pop_front();
        chk("burst_data", int'(wrdata), exp_w);
      end
      chk("done_in_burst", int'(burst_done), 0);
      if (got == n - 1) begin
        wrfull  = 1'b1;
        wrempty = 1'b0;
      end
      got++;
      tick();
    end
    wrfull  = 1'b0;
    wrempty = 1'b0;
    exp_cnt++;
    chk("burst_len", got, eff);
    chk("sb_empty", sb_q.size(), 0);
    chk("end_req", int'(wrreq), 0);
    chk("end_done", int'(burst_done), 1);
    chk("end_cnt", int'(burst_cnt), exp_cnt);
    chk("end_hold", int'(wrdata), (eff - 1) % (1 << DATA_W));
    sb_q.delete();
    tick();
    chk("done_pulse_1cyc", int'(burst_done), 0);
    tick();
    chk("no_rerun_req", int'(wrreq), 0);
    chk("idle_hold", int'(wrdata), (eff - 1) % (1 << DATA_W));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_req", int'(wrreq), 0);
    chk("rst_data", int'(wrdata), 0);
    chk("rst_done", int'(burst_done), 0);
    chk("rst_cnt", int'(burst_cnt), 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_idle", int'(wrreq), 0);

    // reset asserted mid-burst at wrdata=0x23
    start_burst(1'b0);
    for (int k = 0; k < 'h23; k++) tick();
    chk("pre_rst_data", int'(wrdata), 'h23);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", int'(wrreq), 0);
    chk("midrst_data", int'(wrdata), 0);
    chk("midrst_cnt", int'(burst_cnt), 0);
    chk("midrst_done", int'(burst_done), 0);
    tick();
    chk("midrst_done2", int'(burst_done), 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("rst_needs_empty", int'(wrreq), 0);
    chk("rst_cnt_kept", int'(burst_cnt), 0);

    // wrfull in IDLE is ignored
    wrfull = 1'b1;
    tick();
    tick();
    chk("idle_full_req", int'(wrreq), 0);
    chk("idle_full_done", int'(burst_done), 0);
    wrfull = 1'b0;

    start_burst(1'b0);
    finish_burst(10);

    start_burst(1'b0);
    finish_burst('hFA);

    start_burst(1'b0);
    finish_burst(260);

    start_burst(1'b1);
    finish_burst(5);

    start_burst(1'b0);
    finish_burst(DEPTH + 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr.md
FIFO_WR -- requirements
Module: fifo_wr

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: width of the write data word.
REQ-002 SHALL provide parameter DEPTH, default 256: FIFO depth in words, used by the burst limit.
REQ-003 SHALL provide parameter WAIT_CYC, default 3: settle cycles between detecting empty and starting a burst (covers write-side flag latency).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wrempty  input  1  FIFO write-side empty flag.
REQ-007 SHALL have port wrfull  input  1  FIFO write-side full flag.
REQ-008 SHALL have port wrreq  output  1  write request to the FIFO, registered.
REQ-009 SHALL have port wrdata  output  DATA_W  write data, registered, valid while wrreq=1.
REQ-010 SHALL have port burst_done  output  1  one-cycle pulse marking the end of a burst.
REQ-011 SHALL have port burst_cnt  output  16  count of completed bursts.

Function
REQ-012 SHALL implement a state machine with states IDLE, WAIT and WRITE.
REQ-013 IDLE: wrreq=0; on an edge with wrempty=1, SHALL go to WAIT and clear the settle counter.
REQ-014 WAIT: SHALL count settle cycles; on the edge where the counter reaches WAIT_CYC-1, SHALL go to WRITE and set wrreq=1 and wrdata=0 on that same edge; WAIT_CYC=0 SHALL behave as 1.
REQ-015 WAIT: wrempty dropping SHALL NOT abort the wait; the burst starts regardless.
REQ-016 WRITE: on each edge with wrreq=1 and no stop condition, wrdata SHALL increment by 1, wrapping from 2^DATA_W-1 to 0.
REQ-017 WRITE: on an edge with wrfull=1, SHALL clear wrreq, return to IDLE, assert burst_done for exactly one cycle and increment burst_cnt.
REQ-018 burst_cnt SHALL wrap from 16'hFFFF to 0.
REQ-019 The word presented during the cycle wrfull rose SHALL be dropped by the FIFO's own overflow protection; the block SHALL NOT re-send it.
REQ-020 wrempty=1 in WRITE SHALL be ignored; wrfull=1 in IDLE or WAIT SHALL be ignored.
REQ-021 wrdata SHALL hold its last value whenever wrreq=0.
REQ-022 A new burst SHALL start only after a fresh IDLE->WAIT pass; there are no back-to-back bursts without the settle delay.

Reset
REQ-023 While rst=1, SHALL force state=IDLE, wrreq=0, wrdata=0, burst_done=0, burst_cnt=0, and clear the settle and word counters asynchronously.
REQ-024 A reset asserted mid-burst SHALL drop wrreq immediately, SHALL NOT pulse burst_done, and SHALL NOT count the burst.
REQ-025 After rst falls, the first burst SHALL require wrempty=1 sampled in IDLE.

Configuration
REQ-026 Macro FIFO_WR_BURST_LIMIT_EN defined: an internal word counter, cleared at burst start, SHALL count edges with wrreq=1; the burst SHALL end (as in REQ-017) on the edge where DEPTH words have been presented, or on wrfull, whichever comes first.
REQ-027 Macro FIFO_WR_BURST_LIMIT_EN undefined: the word counter SHALL NOT exist, and the burst SHALL end only on wrfull.

Verification
REQ-028 Reset scenario: rst=1 mid-burst, wrdata=0x23 -> wrreq=0 and wrdata=0 immediately, burst_cnt=0, no burst_done pulse.
REQ-029 Basic burst scenario: wrempty=1 with WAIT_CYC=3 -> wrreq rises on the 4th edge after wrempty is sampled, and wrdata runs 0,1,2,... one per cycle.
REQ-030 Full-stop scenario: wrfull rises while wrdata=0xF9 -> wrreq=0 on the next edge, burst_done pulses 1 cycle, burst_cnt 0->1, wrdata holds 0xF9.
REQ-031 Wrap scenario: DATA_W=4, no wrfull for 20 writes -> wrdata sequence 0..15,0,1,2,3.
REQ-032 Limit scenario: FIFO_WR_BURST_LIMIT_EN defined, DEPTH=8, wrfull held 0 -> exactly 8 cycles of wrreq=1 (data 0..7), then burst_done; with the macro undefined, wrreq stays high.
REQ-033 Ignore scenario: wrfull=1 during WAIT and wrempty=1 during WRITE -> no state change; the burst starts and continues normally.
